song_sequencer: RTL
===================

Name: song_sequencer

Overview:
Game-level controller for the falling-note datapath. Owns the row-shift timebase and feeds one 4-lane note row per shift from a song ROM into the note shifter. Judges the shifter's bottom row against the player's buttons and keeps score, combo and lives. Runs the game state machine (idle, count-in, play, drain, pause, over) and sits between the button/debounce logic and the shifter/display path.

Parameters:
TICK_DIV, 35000000, clk cycles per row shift (must be >= 4)
SONG_LEN, 64, number of note rows in the song ROM
ADDR_W, 6, song ROM address width (2**ADDR_W >= SONG_LEN)
COUNTIN_ROWS, 10, empty rows shifted before the first note
MAX_LIVES, 5, lives at game start (fits 3 bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0)
start_btn  in  1  raw start button, level
pause_btn  in  1  raw pause button, level
buttons  in  4  raw lane buttons, bit i = lane i
check  in  4  shifter bottom row (lane bits)
shift_tick  out  1  one-cycle shift strobe to shifter
note_data  out  4  row inserted at shifter top on shift_tick
shifter_reset  out  1  active-high clear to shifter
shifter_run  out  1  shifter enable (maps to shifter start)
score  out  16  saturating score
combo  out  8  consecutive hits, saturating
lives  out  3  remaining lives
state  out  3  current FSM state code
game_over  out  1  high in OVER

Behaviour:
- Reset (reset==0 at posedge): state IDLE, divider 0, addr 0, score 0, combo 0, lives MAX_LIVES, shift_tick 0, note_data 0, shifter_reset 1, shifter_run 0, game_over 0, press mask 0, synchronizers 0. Mid-game reset behaves identically.
- Inputs: start_btn, pause_btn and buttons each pass a 2-flop synchronizer plus a previous-value flop. Edge = sync & ~prev. Pin-to-edge latency is 3 cycles.
- State codes: IDLE=0, COUNTIN=1, PLAY=2, DRAIN=3, PAUSE=4, OVER=5.
- Divider: counts only in COUNTIN/PLAY/DRAIN and holds its value in PAUSE. When it equals TICK_DIV-1: shift_tick=1 for that cycle and the divider wraps to 0. Otherwise shift_tick=0.
- IDLE: shifter_reset=1, shifter_run=0. On start edge: go to COUNTIN, clear score/combo/addr/tick counter, set lives=MAX_LIVES. shifter_reset stays high for that one transition cycle, then 0.
- COUNTIN: note_data=0, no judging. After the COUNTIN_ROWS-th tick, go to PLAY with addr=0.
- PLAY: note_data=rom[addr]. Addr increments on each tick. The tick taken with addr==SONG_LEN-1 moves to DRAIN.
- DRAIN: note_data=0. After 10 ticks (the visible rows), go to OVER.
- shifter_run=1 in COUNTIN/PLAY/DRAIN; 0 in IDLE, PAUSE and OVER.
- Judging is active in PLAY and DRAIN only.
  - Window = cycles between ticks. press_mask accumulates the OR of lane rising edges during the window. An edge in the tick cycle belongs to the next window.
  - On each tick, evaluate the pre-shift check value and clear press_mask.
  - check==0 and mask==0: no change.
  - check!=0 and mask==check: hit. score += (combo>=8 ? 2 : 1), saturating at 16'hFFFF. combo += 1, saturating at 255.
  - Any other case (wrong lanes, missed note, press on empty row): miss. combo=0, lives -= 1, floor 0.
- lives reaching 0 goes to OVER on that same tick. This has priority over the song-end and drain-end transitions.
- Pause: a pause edge in COUNTIN/PLAY/DRAIN saves the state and enters PAUSE. In PAUSE the divider is frozen, lane edges are ignored, and press_mask is held. The next pause edge returns to the saved state with the divider unchanged. A pause edge in IDLE or OVER is ignored.
- OVER: game_over=1, score/combo/lives held. A start edge goes to IDLE. A start edge during COUNTIN/PLAY/DRAIN/PAUSE is ignored.
- Simultaneous start and pause edges: start is evaluated first; pause is considered only if start is not acted on.
- ROM read is registered, one cycle after the addr update. note_data is stable well before the next tick because TICK_DIV >= 4.

Decomposition:
- Package gh_pkg: state enum (codes above), NUM_LANES=4, VISIBLE_ROWS=10, SCORE_W=16, COMBO_BONUS_TH=8.
- Sub-module song_rom: ADDR_W address in, 4-bit row out, registered read, initialised from a song file. It is the only sub-module.
- Synchronizers and edge detection stay inline.

Test Plan (TICK_DIV=4, SONG_LEN=4, COUNTIN_ROWS=2, MAX_LIVES=2, rom={1,2,4,8}):
1. Hold reset=0 for 2 cycles, then release -> state=0, lives=2, score=0, shifter_reset=1, shift_tick=0. No ticks over 20 cycles.
2. Pulse start -> shifter_reset high through the transition cycle, state=1. shift_tick every 4 cycles. After 2 ticks state=2 and note_data=4'b0001. Across 4 ticks note_data steps 1,2,4,8, then state=3.
3. In PLAY drive check=4'b0101 and press lanes 0 and 2 mid-window -> at tick score=1, combo=1. Preload combo to 8 and repeat the hit -> score +=2, combo=9.
4. check=4'b0010 with no press, then check=0 with a lane-3 press -> two misses, combo=0, lives 2->1->0, state=5 and game_over=1 on the second tick, shift_tick stops.
5. Pause edge 1 cycle after a tick, hold 30 cycles, then pause edge again -> no ticks and divider held during PAUSE. Next tick comes 3 cycles after resume (beyond sync latency) and the pre-pause state is restored.
6. Complete the song with all hits -> DRAIN for 10 ticks, then OVER. A start edge returns to IDLE. Assert reset=0 mid-PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/gh_pkg.sv
// Shared types and constants for the falling-note game controller.
package gh_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COUNTIN = 3'd1,
      ST_PLAY    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_PAUSE   = 3'd4,
      ST_OVER    = 3'd5
   } gh_state_e;

   localparam int NUM_LANES      = 4;
   localparam int VISIBLE_ROWS   = 10;
   localparam int SCORE_W        = 16;
   localparam int COMBO_BONUS_TH = 8;

endpackage

// File: rtl/song_rom.sv
// Song note ROM: one lane mask per row, registered read. Contents come from
// SONG_DATA, which is generated from the song file (row i at bits [4i+3:4i]).
module song_rom
   import gh_pkg::*;
#(
   parameter int SONG_LEN = 64,
   parameter int ADDR_W   = 6,
   parameter logic [NUM_LANES*SONG_LEN-1:0] SONG_DATA = {SONG_LEN{4'h1}}
) (
   input  logic                 clk,
   input  logic [ADDR_W-1:0]    addr,
   output logic [NUM_LANES-1:0] data
);

   // Addresses past the end of the song read back as empty rows.
   always_ff @(posedge clk) begin
      data <= '0;
      for (int i = 0; i < SONG_LEN; i++) begin
         if (addr == ADDR_W'(i)) data <= SONG_DATA[NUM_LANES*i +: NUM_LANES];
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// Game controller: row-shift timebase, song feed to the note shifter,
// bottom-row judging with score/combo/lives, and the game state machine.
//
// state   | meaning
// IDLE    | shifter held in reset, waiting for start
// COUNTIN | empty rows shifted before the song
// PLAY    | song rows fed from ROM, judging active
// DRAIN   | empty rows until the last note leaves the screen, judging active
// PAUSE   | timebase frozen, returns to the saved state on pause
// OVER    | results held, start returns to IDLE
module song_sequencer
   import gh_pkg::*;
#(
   parameter int TICK_DIV     = 35000000,
   parameter int SONG_LEN     = 64,
   parameter int ADDR_W       = 6,
   parameter int COUNTIN_ROWS = 10,
   parameter int MAX_LIVES    = 5,
   parameter logic [NUM_LANES*SONG_LEN-1:0] SONG_DATA = {SONG_LEN{4'h1}}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_btn,
   input  logic                 pause_btn,
   input  logic [NUM_LANES-1:0] buttons,
   input  logic [NUM_LANES-1:0] check,
   output logic                 shift_tick,
   output logic [NUM_LANES-1:0] note_data,
   output logic                 shifter_reset,
   output logic                 shifter_run,
   output logic [SCORE_W-1:0]   score,
   output logic [7:0]           combo,
   output logic [2:0]           lives,
   output logic [2:0]           state,
   output logic                 game_over
);

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int ROW_W = 8;

   logic                 start_s1, start_s2, start_prev;
   logic                 pause_s1, pause_s2, pause_prev;
   logic [NUM_LANES-1:0] btn_s1, btn_s2, btn_prev;
   logic                 start_edge, pause_edge;
   logic [NUM_LANES-1:0] btn_edge;

   gh_state_e            state_q, state_d, saved_q, saved_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ROW_W-1:0]     rows_q, rows_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [7:0]           combo_q, combo_d;
   logic [2:0]           lives_q, lives_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic [NUM_LANES-1:0] rom_data;

   logic                 running, tick, judge, hit, miss;
   logic [2:0]           lives_dec;
   logic [SCORE_W:0]     score_sum;

   song_rom #(
      .SONG_LEN  (SONG_LEN),
      .ADDR_W    (ADDR_W),
      .SONG_DATA (SONG_DATA)
   ) u_rom (
      .clk  (clk),
      .addr (addr_q),
      .data (rom_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_prev <= 1'b0;
         pause_s1 <= 1'b0;
         pause_s2 <= 1'b0;
         pause_prev <= 1'b0;
         btn_s1 <= '0;
         btn_s2 <= '0;
         btn_prev <= '0;
      end else begin
         start_s1 <= start_btn;
         start_s2 <= start_s1;
         start_prev <= start_s2;
         pause_s1 <= pause_btn;
         pause_s2 <= pause_s1;
         pause_prev <= pause_s2;
         btn_s1 <= buttons;
         btn_s2 <= btn_s1;
         btn_prev <= btn_s2;
      end
   end

   assign start_edge = start_s2 & ~start_prev;
   assign pause_edge = pause_s2 & ~pause_prev;
   assign btn_edge   = btn_s2 & ~btn_prev;

   assign running   = (state_q == ST_COUNTIN) || (state_q == ST_PLAY) || (state_q == ST_DRAIN);
   assign tick      = running && (div_q == DIV_W'(TICK_DIV - 1));
   assign judge     = tick && ((state_q == ST_PLAY) || (state_q == ST_DRAIN));
   assign hit       = (check != '0) && (mask_q == check);
   assign miss      = !hit && !((check == '0) && (mask_q == '0));
   assign lives_dec = (lives_q == '0) ? '0 : lives_q - 3'd1;
   assign score_sum = {1'b0, score_q} +
                      ((combo_q >= 8'(COMBO_BONUS_TH)) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));

   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      div_d   = div_q;
      addr_d  = addr_q;
      rows_d  = rows_q;
      score_d = score_q;
      combo_d = combo_q;
      lives_d = lives_q;
      mask_d  = mask_q;

      // A lane edge in the tick cycle opens the next window.
      if (running) begin
         div_d  = tick ? '0 : div_q + 1'b1;
         mask_d = tick ? btn_edge : (mask_q | btn_edge);
      end else if (state_q != ST_PAUSE) begin
         mask_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_COUNTIN;
               score_d = '0;
               combo_d = '0;
               addr_d  = '0;
               div_d   = '0;
               rows_d  = ROW_W'(COUNTIN_ROWS - 1);
               lives_d = 3'(MAX_LIVES);
               mask_d  = '0;
            end
         end
         ST_COUNTIN: begin
            if (tick) begin
               if (rows_q == '0) begin
                  state_d = ST_PLAY;
                  addr_d  = '0;
               end else begin
                  rows_d = rows_q - 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (tick) begin
               addr_d = addr_q + 1'b1;
               if (addr_q == ADDR_W'(SONG_LEN - 1)) begin
                  state_d = ST_DRAIN;
                  rows_d  = ROW_W'(VISIBLE_ROWS - 1);
               end
            end
         end
         ST_DRAIN: begin
            if (tick) begin
               if (rows_q == '0) state_d = ST_OVER;
               else rows_d = rows_q - 1'b1;
            end
         end
         ST_PAUSE: begin
            if (pause_edge) state_d = saved_q;
         end
         ST_OVER: begin
            if (start_edge) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (judge) begin
         if (hit) begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
         end else if (miss) begin
            combo_d = '0;
            lives_d = lives_dec;
            if (lives_dec == '0) state_d = ST_OVER;
         end
      end

      // Pausing on a tick saves the post-tick state; a game that just ended stays over.
      if (running && pause_edge && (state_d != ST_OVER)) begin
         saved_d = state_d;
         state_d = ST_PAUSE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         saved_q <= ST_IDLE;
         div_q   <= '0;
         addr_q  <= '0;
         rows_q  <= '0;
         score_q <= '0;
         combo_q <= '0;
         lives_q <= 3'(MAX_LIVES);
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         div_q   <= div_d;
         addr_q  <= addr_d;
         rows_q  <= rows_d;
         score_q <= score_d;
         combo_q <= combo_d;
         lives_q <= lives_d;
         mask_q  <= mask_d;
      end
   end

   assign shift_tick    = tick;
   assign note_data     = (state_q == ST_PLAY) ? rom_data : '0;
   assign shifter_reset = (state_q == ST_IDLE);
   assign shifter_run   = running;
   assign score         = score_q;
   assign combo         = combo_q;
   assign lives         = lives_q;
   assign state         = state_q;
   assign game_over     = (state_q == ST_OVER);

endmodule
